// File: rtl/cmp_trend_pkg.sv
// Shared types for the comparator trend monitor: debounced state, sample relation
// and the one-hot flag decoder.
package cmp_trend_pkg;

    typedef enum logic [1:0] {
        UNKNOWN = 2'b00,
        EQUAL   = 2'b01,
        ABOVE   = 2'b10,
        BELOW   = 2'b11
    } state_t;

    // Relation codes line up with the state codes so a hit maps straight onto a state
    typedef enum logic [1:0] {
        REL_NONE = 2'b00,
        REL_EQ   = 2'b01,
        REL_GT   = 2'b10,
        REL_LT   = 2'b11
    } rel_t;

    function automatic rel_t decode_flags(input logic aeqb, input logic agtb, input logic altb);
        rel_t rel;
        case ({aeqb, agtb, altb})
            3'b100:  rel = REL_EQ;
            3'b010:  rel = REL_GT;
            3'b001:  rel = REL_LT;
            default: rel = REL_NONE;
        endcase
        return rel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/cmp_trend_monitor.sv
// Debounces the comparator's relation flags into a persistent state, counts
// legal samples per relation and latches a sticky error on non-one-hot samples.
module cmp_trend_monitor
    import cmp_trend_pkg::*;
#(
    parameter int PERSIST = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             aeqb,
    input  logic             agtb,
    input  logic             altb,
    input  logic             clear,
    output logic [1:0]       state_o,
    output logic             change_o,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic             err_o
);

    localparam int SW = $clog2(PERSIST + 1);

    state_t        state_q, state_d;
    rel_t          cand_q, cand_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          change_d;
    logic          err_d;
    rel_t          rel;
    logic [SW:0]   streak_inc;
    logic          take;

    assign rel  = decode_flags(aeqb, agtb, altb);
    assign take = in_valid && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= UNKNOWN;
            cand_q   <= REL_NONE;
            streak_q <= '0;
            change_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            streak_q <= streak_d;
            change_o <= change_d;
            err_o    <= err_d;
        end
    end

    // Streak extends only on repeats of the candidate; a sample matching the
    // current state breaks it, and idle cycles leave it untouched.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        streak_d   = streak_q;
        change_d   = 1'b0;
        err_d      = err_o;
        streak_inc = '0;
        if (clear) begin
            state_d  = UNKNOWN;
            cand_d   = REL_NONE;
            streak_d = '0;
            err_d    = 1'b0;
        end else if (in_valid) begin
            if (rel == REL_NONE) begin
                err_d    = 1'b1;
                streak_d = '0;
            end else if (rel == rel_t'(state_q)) begin
                streak_d = '0;
            end else begin
                if (rel == cand_q) begin
                    streak_inc = {1'b0, streak_q} + (SW+1)'(1);
                end else begin
                    cand_d     = rel;
                    streak_inc = (SW+1)'(1);
                end
                if (streak_inc == (SW+1)'(PERSIST)) begin
                    state_d  = state_t'(rel);
                    streak_d = '0;
                    change_d = 1'b1;
                end else begin
                    streak_d = streak_inc[SW-1:0];
                end
            end
        end
    end

    assign state_o = state_q;

    sat_counter #(.W(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (take && (rel == REL_EQ)),
        .q     (eq_cnt)
    );

    sat_counter #(.W(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (take && (rel == REL_GT)),
        .q     (gt_cnt)
    );

    sat_counter #(.W(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (take && (rel == REL_LT)),
        .q     (lt_cnt)
    );

endmodule

// File: tb/tb_cmp_trend_monitor.sv
// Directed bench for cmp_trend_monitor with PERSIST=3, CNT_W=4 and hand-computed
// expectations for debounce, counters, error flag, clear and reset.
module tb_cmp_trend_monitor;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       aeqb;
    logic       agtb;
    logic       altb;
    logic       clear;
    logic [1:0] state_o;
    logic       change_o;
    logic [3:0] eq_cnt;
    logic [3:0] gt_cnt;
    logic [3:0] lt_cnt;
    logic       err_o;

    int checks = 0;
    int errors = 0;
    int change_pulses;

    localparam logic [2:0] EQ   = 3'b100;
    localparam logic [2:0] GT   = 3'b010;
    localparam logic [2:0] LT   = 3'b001;
    localparam logic [2:0] BAD  = 3'b011;

    cmp_trend_monitor #(.PERSIST(3), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .aeqb     (aeqb),
        .agtb     (agtb),
        .altb     (altb),
        .clear    (clear),
        .state_o  (state_o),
        .change_o (change_o),
        .eq_cnt   (eq_cnt),
        .gt_cnt   (gt_cnt),
        .lt_cnt   (lt_cnt),
        .err_o    (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge capture it, then settle just after the edge
    task automatic applyStimulus(input logic valid, input logic [2:0] flags, input logic clr);
        in_valid = valid;
        {aeqb, agtb, altb} = flags;
        clear = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear = 1'b0;
        {aeqb, agtb, altb} = 3'b000;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        {aeqb, agtb, altb} = 3'b000;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", state_o, 2'b00);
        checkOutput("reset_err", err_o, 1'b0);
        checkOutput("reset_cnt", {eq_cnt, gt_cnt, lt_cnt}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three back-to-back GT samples from UNKNOWN
        applyStimulus(1'b1, GT, 1'b0);
        checkOutput("gt1_state", state_o, 2'b00);
        checkOutput("gt1_cnt", gt_cnt, 4'd1);
        applyStimulus(1'b1, GT, 1'b0);
        checkOutput("gt2_state", state_o, 2'b00);
        checkOutput("gt2_change", change_o, 1'b0);
        applyStimulus(1'b1, GT, 1'b0);
        checkOutput("gt3_state", state_o, 2'b10);
        checkOutput("gt3_change", change_o, 1'b1);
        checkOutput("gt3_cnt", gt_cnt, 4'd3);
        applyStimulus(1'b0, 3'b000, 1'b0);
        checkOutput("gt_idle_change", change_o, 1'b0);
        checkOutput("gt_idle_state", state_o, 2'b10);

        // Hysteresis: LT LT GT LT LT LT in ABOVE
        applyStimulus(1'b1, LT, 1'b0);
        applyStimulus(1'b1, LT, 1'b0);
        checkOutput("hyst_lt2_state", state_o, 2'b10);
        applyStimulus(1'b1, GT, 1'b0);
        applyStimulus(1'b1, LT, 1'b0);
        applyStimulus(1'b1, LT, 1'b0);
        checkOutput("hyst_lt5_state", state_o, 2'b10);
        checkOutput("hyst_lt5_change", change_o, 1'b0);
        applyStimulus(1'b1, LT, 1'b0);
        checkOutput("hyst_final_state", state_o, 2'b11);
        checkOutput("hyst_final_change", change_o, 1'b1);
        checkOutput("hyst_lt_cnt", lt_cnt, 4'd5);
        checkOutput("hyst_gt_cnt", gt_cnt, 4'd4);

        // Gaps: idle cycles carry garbage flags but must neither break nor flag anything
        applyStimulus(1'b1, GT, 1'b0);
        applyStimulus(1'b0, BAD, 1'b0);
        applyStimulus(1'b0, LT, 1'b0);
        applyStimulus(1'b1, GT, 1'b0);
        checkOutput("gap_gt2_state", state_o, 2'b11);
        applyStimulus(1'b0, 3'b000, 1'b0);
        checkOutput("gap_idle_err", err_o, 1'b0);
        applyStimulus(1'b1, GT, 1'b0);
        checkOutput("gap_gt3_state", state_o, 2'b10);
        checkOutput("gap_gt3_change", change_o, 1'b1);
        checkOutput("gap_gt_cnt", gt_cnt, 4'd7);

        // Illegal sample mid-streak restarts the streak and touches no counter
        applyStimulus(1'b1, LT, 1'b0);
        applyStimulus(1'b1, LT, 1'b0);
        applyStimulus(1'b1, BAD, 1'b0);
        checkOutput("bad_err", err_o, 1'b1);
        checkOutput("bad_cnt", {eq_cnt, gt_cnt, lt_cnt}, {4'd0, 4'd7, 4'd7});
        checkOutput("bad_state", state_o, 2'b10);
        applyStimulus(1'b1, LT, 1'b0);
        applyStimulus(1'b1, LT, 1'b0);
        checkOutput("bad_restart_state", state_o, 2'b10);
        applyStimulus(1'b1, LT, 1'b0);
        checkOutput("bad_restart_hit", state_o, 2'b11);
        checkOutput("bad_err_sticky", err_o, 1'b1);
        checkOutput("bad_lt_cnt", lt_cnt, 4'd10);

        // Clear wins over a simultaneous valid sample
        applyStimulus(1'b1, EQ, 1'b1);
        checkOutput("clr_state", state_o, 2'b00);
        checkOutput("clr_err", err_o, 1'b0);
        checkOutput("clr_cnt", {eq_cnt, gt_cnt, lt_cnt}, 12'h000);
        checkOutput("clr_change", change_o, 1'b0);

        // Saturation with 20 EQ samples
        change_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, EQ, 1'b0);
            if (change_o) change_pulses++;
            if (i == 2) checkOutput("sat_eq3_state", state_o, 2'b01);
        end
        checkOutput("sat_eq_cnt", eq_cnt, 4'd15);
        checkOutput("sat_state", state_o, 2'b01);
        checkOutput("sat_pulses", change_pulses, 1);

        // Asynchronous reset with non-zero counters and err set, no edge needed
        applyStimulus(1'b1, BAD, 1'b0);
        applyStimulus(1'b1, GT, 1'b0);
        applyStimulus(1'b1, GT, 1'b0);
        checkOutput("pre_rst_err", err_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_state", state_o, 2'b00);
        checkOutput("async_rst_cnt", {eq_cnt, gt_cnt, lt_cnt}, 12'h000);
        checkOutput("async_rst_err", err_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streak built before reset must be gone: one GT after reset is not a hit
        applyStimulus(1'b1, GT, 1'b0);
        applyStimulus(1'b1, GT, 1'b0);
        checkOutput("post_rst_state", state_o, 2'b00);
        applyStimulus(1'b1, GT, 1'b0);
        checkOutput("post_rst_hit", state_o, 2'b10);
        checkOutput("post_rst_change", change_o, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got 0 expected 1");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/cmp_trend_monitor.md
# cmp_trend_monitor

Downstream consumer of the 4-bit magnitude comparator. It takes the comparator's one-hot relation flags (A==B, A>B, A<B) and turns the raw per-sample result into three things: a debounced relation state with persistence filtering, per-relation saturating event counters, and a sticky protocol-error flag. Its outputs feed status registers and the alarm logic that sit above the comparator stage.

## Interface
Parameters:
- PERSIST, 3: number of consecutive valid samples of one relation required to change state; legal range 1..15.
- CNT_W, 8: width of each saturating event counter.

Ports:
- clk, input, 1: the single clock; all logic is rising-edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: the flags are a sample this cycle.
- aeqb, input, 1: comparator A==B flag.
- agtb, input, 1: comparator A>B flag.
- altb, input, 1: comparator A<B flag.
- clear, input, 1: synchronous soft clear.
- state_o, output, 2: debounced relation. 00 UNKNOWN, 01 EQUAL, 10 ABOVE, 11 BELOW.
- change_o, output, 1: one-cycle pulse when state_o changes.
- eq_cnt, output, CNT_W: count of valid EQ samples.
- gt_cnt, output, CNT_W: count of valid GT samples.
- lt_cnt, output, CNT_W: count of valid LT samples.
- err_o, output, 1: sticky. Set when a valid sample is not one-hot.

## Operation
- Sample classification happens only when in_valid=1.
  - A sample is legal only if exactly one of {aeqb, agtb, altb} is 1.
  - An illegal sample sets err_o, zeroes the streak, updates no counter and does not change state.
- Counters:
  - Each legal sample increments the counter of its relation by 1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- Streak logic uses an internal candidate relation plus a streak count, width ceil(log2(PERSIST+1)).
  - If the sample relation equals the current state: streak=0 and the state holds.
  - Else, if the sample relation equals the candidate: streak increments.
  - Else: candidate is set to the sample relation and streak=1.
  - When the streak would reach PERSIST, the state takes the candidate, streak=0, and change_o=1 for one cycle.
- FSM:
  - UNKNOWN is left only through a persistence hit, to EQUAL, ABOVE or BELOW.
  - Any of those three can move to any other through a persistence hit.
  - No state other than UNKNOWN returns to UNKNOWN, except through reset or clear.
- Cycles with in_valid=0 neither break nor advance the streak.
- clear=1 does the following at the next edge:
  - counters=0, err_o=0, streak=0, candidate=none, state_o=UNKNOWN, change_o=0.
  - clear has priority over a simultaneous valid sample; that sample is dropped.
- Reset: rst_n=0 immediately forces state_o=UNKNOWN, change_o=0, all counters 0, err_o=0, streak 0. Reset mid-streak discards the streak.

## Timing
- All outputs are registered.
- Counters reflect a sample on the edge that captures it, so they are visible the cycle after in_valid.
- State latency: state_o and change_o update on the edge that captures the PERSIST-th consecutive matching sample. With back-to-back valids from UNKNOWN, state_o changes after PERSIST edges.
- PERSIST=1: every legal sample whose relation differs from the state causes an immediate change.
- change_o is never high on two consecutive cycles unless two consecutive samples each complete a transition. That is only possible with PERSIST=1.
- No backpressure. The block accepts one sample every cycle.

## Structure
- Package cmp_trend_pkg holds:
  - the state enum (UNKNOWN, EQUAL, ABOVE, BELOW) with the fixed encodings above;
  - the relation encoding (REL_NONE, REL_EQ, REL_GT, REL_LT);
  - the one-hot decode function mapping flags to a relation, with illegal decoding to REL_NONE.
- Sub-module sat_counter (parameter W; ports clk, rst_n, clr, inc, q) is instantiated three times.
- The FSM and streak logic live in the top level.

## Test plan
All scenarios use PERSIST=3, CNT_W=4.
- Reset: assert rst_n=0 mid-run with counters non-zero -> state_o=00, counters 0, err_o=0 with no clock edge needed.
- Three back-to-back GT samples from UNKNOWN -> state_o=10 with change_o=1 on the 3rd capture edge; gt_cnt=3.
- Hysteresis pattern: in ABOVE, feed LT, LT, GT, LT, LT, LT -> state_o stays 10 until the final LT, then becomes 11; lt_cnt=5, gt_cnt=+1.
- Gaps: GT, idle, idle, GT, idle, GT -> transition on the third GT; idle cycles do not reset the streak.
- Illegal sample: in_valid with agtb=altb=1 mid-streak -> err_o=1 and stays 1; streak restarts; no counter changes. clear -> err_o=0, state UNKNOWN, counters 0.
- Saturation: 20 valid EQ samples -> eq_cnt holds at 15; state_o=01; change_o pulsed exactly once.
